core_dbg_ctrl: RTL

- Run-control debug controller for the pipelined rv32i core; the command-side counterpart to the pipeline trace monitor.
- Accepts halt/resume/step/run-to-PC commands over a valid/ready channel.
- Gates the core through a registered stall line and counts retirements reported by the WB stage.
- Returns one response per command: the resulting state and the last retired PC.

---
 rtl/core_dbg_ctrl_if.sv | 30 +++
 rtl/core_dbg_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/core_dbg_ctrl_if.sv
// ---------------------------------------------------------------------------
// core_dbg_ctrl_if
//   Command/response channel of the run-control debug controller.
//   Two independent valid/ready handshakes:
//     cmd_valid/cmd_ready : command offered by the debugger, op + argument
//     rsp_valid/rsp_ready : one response per command, code + last retired PC
//   Modports:
//     master : the debugger side (drives commands, consumes responses)
//     slave  : the controller side (accepts commands, produces responses)
// ---------------------------------------------------------------------------
interface core_dbg_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;     // 0=HALT, 1=RESUME, 2=STEP, 3=RUN_TO_PC
    logic [31:0] cmd_arg;    // STEP: retire count, RUN_TO_PC: breakpoint PC
    logic        rsp_valid;
    logic        rsp_ready;
    logic [1:0]  rsp_code;   // 0=HALTED, 1=RUNNING, 2=ERR
    logic [31:0] rsp_data;   // last retired PC

    modport master (
        output cmd_valid, cmd_op, cmd_arg, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_code, rsp_data
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, rsp_ready,
        output cmd_ready, rsp_valid, rsp_code, rsp_data
    );
endinterface

// File: rtl/core_dbg_ctrl.sv
// ---------------------------------------------------------------------------
// core_dbg_ctrl
//   Run-control debug controller for the pipelined rv32i core. Accepts
//   HALT / RESUME / STEP / RUN_TO_PC commands, gates the core through a
//   registered stall line, watches WB-stage retirements and returns exactly
//   one response (resulting state + last retired PC) per command.
//
// Ports:
//   clk, rst_n     core clock, asynchronous active-low reset
//   dbg            command/response channel (core_dbg_ctrl_if.slave)
//   retire_valid   one instruction retired at WB this cycle
//   retire_pc      PC of the retiring instruction
//   core_stall     registered stall; high in HALTED and RESP
//   halted         controller is in the HALTED state
//   cycle_count    number of unstalled cycles, wraps at 2^cnt_width
// ---------------------------------------------------------------------------
module core_dbg_ctrl #(
    parameter bit start_halted = 1'b0,
    parameter int cnt_width    = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    core_dbg_ctrl_if.slave       dbg,
    input  logic                 retire_valid,
    input  logic [31:0]          retire_pc,
    output logic                 core_stall,
    output logic                 halted,
    output logic [cnt_width-1:0] cycle_count
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_HALTED,
        ST_STEPPING,
        ST_RUN_TO_PC,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        OP_HALT      = 2'd0,
        OP_RESUME    = 2'd1,
        OP_STEP      = 2'd2,
        OP_RUN_TO_PC = 2'd3
    } op_t;

    localparam logic [1:0] RSP_HALTED  = 2'd0;
    localparam logic [1:0] RSP_RUNNING = 2'd1;
    localparam logic [1:0] RSP_ERR     = 2'd2;

    localparam state_t               RESET_STATE = start_halted ? ST_HALTED : ST_RUN;
    localparam logic [cnt_width-1:0] CNT_ONE     = cnt_width'(1);

    state_t               state, state_n;
    op_t                  cmd_op_e;
    logic                 cmd_fire;
    logic                 rsp_enter;
    logic [1:0]           rsp_code_n;
    logic                 step_load;
    logic                 bp_load;
    logic [cnt_width-1:0] step_rem;
    logic [cnt_width-1:0] step_arg;
    logic [31:0]          bp;
    logic [31:0]          last_pc;
    logic                 rsp_valid_q;
    logic [1:0]           rsp_code_q;
    logic [31:0]          rsp_data_q;

    assign cmd_op_e      = op_t'(dbg.cmd_op);
    assign dbg.cmd_ready = (state != ST_RESP);
    assign cmd_fire      = dbg.cmd_valid && dbg.cmd_ready;
    assign step_arg      = dbg.cmd_arg[cnt_width-1:0];

    assign dbg.rsp_valid = rsp_valid_q;
    assign dbg.rsp_code  = rsp_code_q;
    assign dbg.rsp_data  = rsp_data_q;
    assign halted        = (state == ST_HALTED);

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_n    = state;
        rsp_enter  = 1'b0;
        rsp_code_n = rsp_code_q;
        step_load  = 1'b0;
        bp_load    = 1'b0;

        unique case (state)
            ST_HALTED: begin
                if (cmd_fire) begin
                    unique case (cmd_op_e)
                        OP_HALT: begin
                            rsp_enter  = 1'b1;
                            rsp_code_n = RSP_HALTED;
                        end
                        OP_RESUME: begin
                            rsp_enter  = 1'b1;
                            rsp_code_n = RSP_RUNNING;
                        end
                        OP_STEP: begin
                            state_n   = ST_STEPPING;
                            step_load = 1'b1;
                        end
                        OP_RUN_TO_PC: begin
                            state_n = ST_RUN_TO_PC;
                            bp_load = 1'b1;
                        end
                    endcase
                end
            end

            ST_RUN: begin
                if (cmd_fire) begin
                    rsp_enter  = 1'b1;
                    rsp_code_n = (cmd_op_e == OP_HALT) ? RSP_HALTED : RSP_ERR;
                end
            end

            ST_STEPPING, ST_RUN_TO_PC: begin
                // A command always aborts; if it collides with the completing
                // retire the command's code wins and only one response leaves.
                if (cmd_fire) begin
                    rsp_enter  = 1'b1;
                    rsp_code_n = (cmd_op_e == OP_HALT) ? RSP_HALTED : RSP_ERR;
                end else if (retire_valid &&
                             ((state == ST_STEPPING)  ? (step_rem == CNT_ONE)
                                                      : (retire_pc == bp))) begin
                    rsp_enter  = 1'b1;
                    rsp_code_n = RSP_HALTED;
                end
            end

            ST_RESP: begin
                if (dbg.rsp_ready) begin
                    state_n = (rsp_code_q == RSP_RUNNING) ? ST_RUN : ST_HALTED;
                end
            end

            default: state_n = RESET_STATE;
        endcase

        if (rsp_enter) begin
            state_n = ST_RESP;
        end
    end

    // core_stall follows the next state so it is registered yet lines up
    // with the state register: it rises the cycle after the causing command.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RESET_STATE;
            core_stall <= start_halted;
        end else begin
            state      <= state_n;
            core_stall <= (state_n == ST_HALTED) || (state_n == ST_RESP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pc     <= '0;
            cycle_count <= '0;
            step_rem    <= '0;
            bp          <= '0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= RSP_HALTED;
            rsp_data_q  <= '0;
        end else begin
            if (retire_valid) begin
                last_pc <= retire_pc;
            end

            if (!core_stall) begin
                cycle_count <= cycle_count + CNT_ONE;
            end

            if (step_load) begin
                step_rem <= (step_arg == '0) ? CNT_ONE : step_arg;
            end else if ((state == ST_STEPPING) && retire_valid && (step_rem != '0)) begin
                step_rem <= step_rem - CNT_ONE;
            end

            if (bp_load) begin
                bp <= dbg.cmd_arg;
            end

            // The response carries last_pc including a retire in the same
            // cycle, so a completing STEP/RUN_TO_PC reports that retire's PC.
            if (rsp_enter) begin
                rsp_valid_q <= 1'b1;
                rsp_code_q  <= rsp_code_n;
                rsp_data_q  <= retire_valid ? retire_pc : last_pc;
            end else if ((state == ST_RESP) && dbg.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

endmodule
